// File: rtl/io_dispatch_if.sv
// Beat stream into the dispatcher: packed word, per-lane end-of-object flags,
// and the valid/ready handshake that qualifies them.
interface io_dispatch_if #(
   parameter int DATA_W = 32,
   parameter int NCH    = 4
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [NCH-1:0]    eob;
   logic              in_ready;

   modport master (output in_valid, output in_data, output eob, input  in_ready);
   modport slave  (input  in_valid, input  in_data, input  eob, output in_ready);
endinterface

// File: rtl/io_dispatch_fsm.sv
// Load/calculate dispatcher: distributes packed input words to NCH decompressor
// lanes, counts objects per lane, then hands off to the coordinator for CALC.
module io_dispatch_fsm #(
   parameter int DATA_W = 32,
   parameter int NCH    = 4,
   parameter int NOBJ   = 2
) (
   input  logic              clk,
   input  logic              reset,
   io_dispatch_if.slave      bus,
   input  logic              irq,
   input  logic              process,
   input  logic              ready,
   output logic [DATA_W-1:0] lane_data,
   output logic [NCH-1:0]    start,
   output logic [NCH-1:0]    finished,
   output logic              calc_start,
   output logic              next,
   output logic              busy,
   output logic              err
);
   localparam int CW = $clog2(NOBJ + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECOMP = 2'd1,
      S_CALC   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [NCH-1:0]    fin_q, fin_d;
   logic [NCH-1:0]    start_q, start_d;
   logic [CW-1:0]     cnt_q [NCH];
   logic [CW-1:0]     cnt_d [NCH];
   logic [DATA_W-1:0] lane_data_q, lane_data_d;
   logic              calc_start_q, calc_start_d;
   logic              next_q, next_d;
   logic              err_q, err_d;
   logic              all_fin, in_ready_c, accept, clear_cnt;

   assign all_fin    = &fin_q;
   assign in_ready_c = (state_q == S_DECOMP) && !all_fin;
   assign accept     = bus.in_valid && in_ready_c;
   assign clear_cnt  = (state_q == S_DONE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (irq && !process)           state_d = S_DECOMP;
         S_DECOMP: if (irq && process && all_fin) state_d = S_CALC;
         S_CALC:   if (ready)                     state_d = S_DONE;
         S_DONE:                                  state_d = S_IDLE;
         default:                                 state_d = S_IDLE;
      endcase
   end

   // Output logic; pulses are derived from the transition so they land in the
   // first cycle of the new state once registered.
   always_comb begin
      bus.in_ready = in_ready_c;
      busy         = (state_q != S_IDLE);
      lane_data_d  = accept ? bus.in_data : lane_data_q;
      calc_start_d = (state_d == S_CALC) && (state_q != S_CALC);
      next_d       = (state_d == S_DONE) && (state_q != S_DONE);
      err_d        = err_q;
      if (state_q == S_DECOMP) begin
         if ((irq && process && !all_fin) || (bus.in_valid && all_fin))
            err_d = 1'b1;
      end
   end

   // Per-lane object counters; a finished lane ignores further eob flags.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
      logic          lane_hit;
      logic [CW-1:0] cnt_inc;

      assign lane_hit    = accept && bus.eob[gi] && !fin_q[gi];
      assign cnt_inc     = cnt_q[gi] + CW'(1);
      assign cnt_d[gi]   = clear_cnt ? '0 : (lane_hit ? cnt_inc : cnt_q[gi]);
      assign fin_d[gi]   = clear_cnt ? 1'b0 :
                           (lane_hit ? (cnt_inc == CW'(NOBJ)) : fin_q[gi]);
      assign start_d[gi] = accept && !fin_q[gi];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fin_q        <= '0;
         start_q      <= '0;
         lane_data_q  <= '0;
         calc_start_q <= 1'b0;
         next_q       <= 1'b0;
         err_q        <= 1'b0;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         fin_q        <= fin_d;
         start_q      <= start_d;
         lane_data_q  <= lane_data_d;
         calc_start_q <= calc_start_d;
         next_q       <= next_d;
         err_q        <= err_d;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign lane_data  = lane_data_q;
   assign start      = start_q;
   assign finished   = fin_q;
   assign calc_start = calc_start_q;
   assign next       = next_q;
   assign err        = err_q;
endmodule
